// File: rtl/uart_tx_fifo_if.sv
// Byte-push side and UartTxEn side of the transmit buffer, bundled as one port.
// slave = the FIFO itself, master = whoever drives push and the transmitter status.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic                   push;
  logic [WIDTH-1:0]       push_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [WIDTH-1:0]       tx_data;
  logic                   tx_valid;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   idle;

  modport slave (
    input  push, push_data, tx_busy, tx_done,
    output full, empty, count, overflow, tx_data, tx_valid, idle
  );

  modport master (
    output push, push_data, tx_busy, tx_done,
    input  full, empty, count, overflow, tx_data, tx_valid, idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH-entry byte queue feeding UartTxEn; push into empty idle FIFO gives tx_valid two edges later.
// No backpressure on push: a push while full is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          syncReset,
  uart_tx_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, push_ok, launch;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = bus.push && !full && !syncReset;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // launch is the single pop point: a byte leaves storage only as it is strobed out
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.tx_busy) begin
          state_d = S_SEND;
          launch  = 1'b1;
        end
      end
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (bus.tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (syncReset) begin
      state_d = S_IDLE;
      launch  = 1'b0;
    end
  end

  always_comb begin
    bus.tx_valid = (state_q == S_SEND);
    bus.idle     = empty && (state_q == S_IDLE);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    count_d    = count_q + CW'(push_ok) - CW'(launch);
    overflow_d = bus.push && full;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (launch) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (syncReset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tx_data_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.push_data;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
endmodule
